// File: rtl/uart_echo_responder.sv
// uart_echo_responder: takes bytes from the UART receiver (rdy / rdy_clr
// handshake), queues them in a small FIFO and replays them to the UART
// transmitter (wr_en / busy handshake), so every received byte is echoed.
//
// Optional build macro:
//   ECHO_UPCASE_EN - at the pop, lower-case ASCII 'a'..'z' is echoed as
//                    'A'..'Z'; every other byte passes unchanged.
module uart_echo_responder #(
    parameter int DEPTH         = 8,
    parameter int START_TIMEOUT = 16,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    output logic          rx_rdy_clr,
    input  logic          tx_busy,
    output logic          tx_wr_en,
    output logic [7:0]    tx_data,
    input  logic          enable,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic          start_err,
    output logic          idle
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(START_TIMEOUT - 1);

    typedef enum logic {
        I_WAIT,
        I_CLR
    } i_state_t;

    typedef enum logic [1:0] {
        E_IDLE,
        E_START,
        E_DONE
    } e_state_t;

    i_state_t         i_state, i_next;
    e_state_t         e_state, e_next;
    logic [DEPTH-1:0][7:0] mem;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [TW-1:0]    tmr, tmr_next;
    logic             push_req, push_ok, pop, err_set;
    logic [7:0]       pop_data;

    // Byte transform applied on the way out of the FIFO.
    function automatic logic [7:0] echo_map(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A)
            return b & 8'hDF;
        else
            return b;
`else
        return b;
`endif
    endfunction

    assign pop_data = echo_map(mem[rd_ptr]);

    // A byte landing on a full FIFO still fits if the head leaves this cycle.
    assign push_ok = push_req && ((fifo_count != FULL) || pop);

    // Ingress next-state: capture once per rdy level, then wait for it to drop.
    always_comb begin
        i_next   = i_state;
        push_req = 1'b0;
        case (i_state)
            I_WAIT: begin
                if (rx_rdy) begin
                    push_req = 1'b1;
                    i_next   = I_CLR;
                end
            end
            I_CLR: begin
                if (!rx_rdy)
                    i_next = I_WAIT;
            end
            default: i_next = I_WAIT;
        endcase
    end

    // Egress next-state: pop, wait for busy to rise (bounded), wait for busy to fall.
    always_comb begin
        e_next   = e_state;
        pop      = 1'b0;
        tmr_next = tmr;
        err_set  = 1'b0;
        case (e_state)
            E_IDLE: begin
                if ((fifo_count != '0) && enable && !tx_busy) begin
                    pop      = 1'b1;
                    tmr_next = '0;
                    e_next   = E_START;
                end
            end
            E_START: begin
                if (tx_busy) begin
                    e_next = E_DONE;
                end else if (tmr == TLAST) begin
                    // Transmitter never took the byte; drop it, no retry.
                    err_set = 1'b1;
                    e_next  = E_IDLE;
                end else begin
                    tmr_next = tmr + 1'b1;
                end
            end
            E_DONE: begin
                if (!tx_busy)
                    e_next = E_IDLE;
            end
            default: e_next = E_IDLE;
        endcase
    end

    // State registers, pointers, occupancy and the egress timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state    <= I_WAIT;
            e_state    <= E_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tmr        <= '0;
        end else begin
            i_state <= i_next;
            e_state <= e_next;
            tmr     <= tmr_next;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= rx_data;
    end

    // Registered handshake strobes, output byte, sticky flags and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_clr <= 1'b0;
            tx_wr_en   <= 1'b0;
            tx_data    <= 8'h00;
            overflow   <= 1'b0;
            start_err  <= 1'b0;
            idle       <= 1'b1;
        end else begin
            // Clear is pulsed even for a dropped byte so the receiver re-arms.
            rx_rdy_clr <= push_req;
            tx_wr_en   <= pop;
            if (pop)
                tx_data <= pop_data;
            if (push_req && !push_ok)
                overflow <= 1'b1;
            if (err_set)
                start_err <= 1'b1;
            idle <= (i_state == I_WAIT) && (e_state == E_IDLE) && (fifo_count == '0);
        end
    end

endmodule
